// File: rtl/cfi_pkg.sv
// Shared types for the CFI response path: violation codes, log entry
// layout and the responder FSM state encoding.
package cfi_pkg;

    typedef logic [3:0] cfi_code_t;

    localparam cfi_code_t CFI_NONE         = 4'h0;
    localparam cfi_code_t CFI_JALR_NO_ADD  = 4'h1;
    localparam cfi_code_t CFI_RET_MISMATCH = 4'h2;

    // Log entries carry the widest supported PC; narrower cores zero-extend.
    localparam int unsigned CFI_PC_W = 64;

    typedef struct packed {
        logic [CFI_PC_W-1:0] pc;
        cfi_code_t           code;
    } cfi_log_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_HOLDOFF = 2'd2,
        ST_LOCKED  = 2'd3
    } cfi_resp_state_e;

endpackage

// File: rtl/cfi_log_fifo.sv
// Small synchronous FIFO of CFI log entries. Pointers carry one extra wrap
// bit so full/empty fall out of a compare. When full, a same-cycle pop frees
// the slot so the push is still accepted.
module cfi_log_fifo
    import cfi_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           flush_i,
    input  logic           push_i,
    input  cfi_log_entry_t entry_i,
    input  logic           pop_i,
    output cfi_log_entry_t head_o,
    output logic           full_o,
    output logic           empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]    r_wptr;
    logic [AW:0]    r_rptr;
    cfi_log_entry_t r_mem [DEPTH];
    logic           w_push_ok;
    logic           w_pop_ok;

    assign empty_o   = (r_wptr == r_rptr);
    assign full_o    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop_ok  = pop_i && !empty_o;
    assign w_push_ok = push_i && (!full_o || w_pop_ok);
    assign head_o    = r_mem[r_rptr[AW-1:0]];

    // Pointer update; flush discards every entry at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
            if (w_pop_ok)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk_i) begin
        if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= entry_i;
    end

endmodule

// File: rtl/cfi_alert_responder.sv
// CFI alert responder: logs checker violations, presents the oldest one to
// the core controller as an exception request (req/ack), counts events and
// escalates to a sticky halt at a threshold.
// Optional macro CFI_RESP_TIMEOUT_EN adds an ack timeout in REQ that pops
// the head and locks the responder.
module cfi_alert_responder
    import cfi_pkg::*;
#(
    parameter int unsigned VLEN           = 64,
    parameter int unsigned LOG_DEPTH      = 4,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned ESC_THRESHOLD  = 4,
    parameter int unsigned HOLDOFF_CYCLES = 8
`ifdef CFI_RESP_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 256
`endif
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             det_valid_i,
    input  logic [VLEN-1:0]  det_pc_i,
    input  logic [3:0]       det_code_i,
    output logic             exc_req_o,
    output logic [VLEN-1:0]  exc_tval_o,
    output logic [3:0]       exc_code_o,
    input  logic             exc_ack_i,
    input  logic             clear_i,
    output logic             halt_o,
    output logic [CNT_W-1:0] event_cnt_o,
    output logic [CNT_W-1:0] drop_cnt_o,
    output logic             overflow_o
);
    localparam int unsigned HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    cfi_resp_state_e r_state;
    cfi_resp_state_e w_state_nxt;
    logic [HW-1:0]   r_hold;
    logic [CNT_W-1:0] r_event_cnt;
    logic [CNT_W-1:0] r_drop_cnt;
    logic            r_overflow;

    cfi_log_entry_t  w_push_entry;
    cfi_log_entry_t  w_head;
    logic            w_full;
    logic            w_empty;
    logic            w_clear;
    logic            w_esc;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic            w_tmo_expire;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A pending request cannot be cleared away; software retries later.
    assign w_clear = clear_i && (r_state != ST_REQ);
    assign w_esc   = (r_event_cnt >= CNT_W'(ESC_THRESHOLD));
    assign w_pop   = (r_state == ST_REQ) && (exc_ack_i || w_tmo_expire);
    assign w_push  = det_valid_i && !w_clear;
    assign w_drop  = w_push && w_full && !w_pop;

    assign w_push_entry.pc   = CFI_PC_W'(det_pc_i);
    assign w_push_entry.code = det_code_i;

    cfi_log_fifo #(
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (w_clear),
        .push_i  (w_push),
        .entry_i (w_push_entry),
        .pop_i   (w_pop),
        .head_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

`ifdef CFI_RESP_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] r_tmo;

    assign w_tmo_expire = (r_state == ST_REQ) && !exc_ack_i && (r_tmo == TW'(TIMEOUT_CYCLES - 1));

    // Count consecutive un-acked REQ cycles; restart on any exit from REQ.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                               r_tmo <= '0;
        else if ((r_state == ST_REQ) && !exc_ack_i && !w_tmo_expire) r_tmo <= r_tmo + TW'(1);
        else                                                       r_tmo <= '0;
    end
`else
    assign w_tmo_expire = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic; escalation noticed in REQ waits for the handshake.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (clear_i)       w_state_nxt = ST_IDLE;
                else if (w_esc)    w_state_nxt = ST_LOCKED;
                else if (!w_empty) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (exc_ack_i)         w_state_nxt = ST_HOLDOFF;
                else if (w_tmo_expire) w_state_nxt = ST_LOCKED;
            end
            ST_HOLDOFF: begin
                if (clear_i)          w_state_nxt = ST_IDLE;
                else if (w_esc)       w_state_nxt = ST_LOCKED;
                else if (r_hold == '0) w_state_nxt = ST_IDLE;
            end
            ST_LOCKED: begin
                if (clear_i) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; head fields are zeroed outside REQ.
    always_comb begin
        exc_req_o  = (r_state == ST_REQ);
        halt_o     = (r_state == ST_LOCKED);
        exc_tval_o = '0;
        exc_code_o = CFI_NONE;
        if (r_state == ST_REQ) begin
            exc_tval_o = w_head.pc[VLEN-1:0];
            exc_code_o = w_head.code;
        end
    end

    // Holdoff counter: loaded on ack, runs down while in HOLDOFF.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                     r_hold <= '0;
        else if ((r_state == ST_REQ) && exc_ack_i)       r_hold <= HW'(HOLDOFF_CYCLES - 1);
        else if ((r_state == ST_HOLDOFF) && (r_hold != '0)) r_hold <= r_hold - HW'(1);
    end

    // Event/drop counters and sticky overflow, all wiped by an honoured clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_event_cnt <= '0;
            r_drop_cnt  <= '0;
            r_overflow  <= 1'b0;
        end else if (w_clear) begin
            r_event_cnt <= '0;
            r_drop_cnt  <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (det_valid_i) r_event_cnt <= sat_inc(r_event_cnt);
            if (w_drop) begin
                r_drop_cnt <= sat_inc(r_drop_cnt);
                r_overflow <= 1'b1;
            end
        end
    end

    assign event_cnt_o = r_event_cnt;
    assign drop_cnt_o  = r_drop_cnt;
    assign overflow_o  = r_overflow;

endmodule

// File: doc/cfi_alert_responder.md
Name: cfi_alert_responder

Overview:
- Response end of the CFI monitoring path. Accepts one-cycle violation pulses (PC + 4-bit code) from the commit-stage CFI checkers and logs them in a small FIFO.
- Presents the oldest logged violation to the core controller as an exception request, using a req/ack handshake.
- Counts violations and escalates to a sticky halt once a threshold is reached.

Parameters:
- VLEN, 64, width of violation PC / exception tval.
- LOG_DEPTH, 4, FIFO entries; power of two, >=2.
- CNT_W, 8, width of saturating event and drop counters.
- ESC_THRESHOLD, 4, event count at which escalation to halt occurs; 1..2^CNT_W-1.
- HOLDOFF_CYCLES, 8, idle cycles enforced between consecutive exception requests; >=1.
- TIMEOUT_CYCLES, 256, ack timeout (optional feature only).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- det_valid_i  in  1  violation pulse from a CFI checker, one event per cycle.
- det_pc_i  in  VLEN  PC of the offending instruction; valid with det_valid_i.
- det_code_i  in  4  violation code (cfi_code_t); valid with det_valid_i.
- exc_req_o  out  1  exception request to the controller.
- exc_tval_o  out  VLEN  PC of the head entry; stable while exc_req_o=1.
- exc_code_o  out  4  code of the head entry; stable while exc_req_o=1.
- exc_ack_i  in  1  controller accepted the exception.
- clear_i  in  1  software clear of the log, counters and lock.
- halt_o  out  1  escalation halt request; sticky.
- event_cnt_o  out  CNT_W  saturating count of detections.
- drop_cnt_o  out  CNT_W  saturating count of detections lost because the FIFO was full.
- overflow_o  out  1  sticky; set on the first drop.

Behaviour:
- Reset (async, rst_ni=0): state IDLE; FIFO empty; all outputs 0, including counters and exc_tval_o/exc_code_o.
- Detection: det_valid_i=1 increments event_cnt (saturates at 2^CNT_W-1).
  - FIFO not full: push {pc, code}.
  - FIFO full: no push; drop_cnt++ (saturating); overflow_o<=1.
  - Exception: a same-cycle pop (ack) frees the slot, so the push succeeds with no drop.
- FIFO pointers are log2(LOG_DEPTH)+1 bits.
  - Full when the MSBs differ and the low bits are equal.
  - Wrap-around is natural.
- FSM states: IDLE, REQ, HOLDOFF, LOCKED.
  - IDLE:
    - event_cnt>=ESC_THRESHOLD -> LOCKED.
    - Else if FIFO non-empty -> REQ next cycle.
    - Minimum latency: push at cycle N gives exc_req_o=1 at N+2.
  - REQ:
    - exc_req_o=1; exc_tval_o/exc_code_o = FIFO head, held constant.
    - exc_req_o never drops without exc_ack_i.
    - On exc_ack_i: pop head; exc_req_o=0 the next cycle; -> HOLDOFF, with holdoff counter loaded to HOLDOFF_CYCLES-1.
  - HOLDOFF:
    - Counter decrements each cycle.
    - event_cnt>=ESC_THRESHOLD -> LOCKED immediately.
    - Otherwise, at 0 -> IDLE.
  - LOCKED:
    - halt_o=1, exc_req_o=0.
    - Detections are still logged and counted.
    - Leaves only on clear_i -> IDLE.
- Escalation reached during REQ is deferred until the handshake completes (REQ -> HOLDOFF -> LOCKED in the first HOLDOFF cycle).
- clear_i, honoured in IDLE, HOLDOFF and LOCKED:
  - Flushes the FIFO and zeroes event_cnt, drop_cnt and overflow_o.
  - halt_o<=0; state -> IDLE.
  - A det_valid_i arriving in the same cycle is discarded.
  - clear_i in REQ is ignored entirely; software retries.
- exc_ack_i outside REQ is ignored.
- Reset mid-REQ drops the request immediately; no handshake completion is required.

Optional Feature:
- Macro: CFI_RESP_TIMEOUT_EN.
- Defined:
  - A timeout counter runs while in REQ.
  - If exc_ack_i is absent for TIMEOUT_CYCLES consecutive cycles: pop head, exc_req_o=0, -> LOCKED (halt_o=1).
  - An ack in the same cycle as expiry wins; normal path to HOLDOFF.
- Undefined: no timeout logic; REQ waits indefinitely.

Decomposition:
- cfi_pkg:
  - cfi_code_t (logic [3:0]).
  - Code constants: CFI_NONE=4'h0, CFI_JALR_NO_ADD=4'h1, CFI_RET_MISMATCH=4'h2.
  - cfi_log_entry_t struct {pc, code}.
  - cfi_resp_state_e enum.
- Sub-module cfi_log_fifo: parameterised synchronous FIFO of cfi_log_entry_t with push/pop/full/empty and pop-before-push when full.

Test Plan:
- Single detection pc=0x8000_0010, code=1, ack 3 cycles after req -> exc_req_o rises 2 cycles after the pulse; tval=0x8000_0010 and code=1 held until ack; exc_req_o=0 next cycle; no new req for 8 cycles.
- 6 back-to-back detections, no ack, LOG_DEPTH=4 -> 4 logged; drop_cnt_o=2; overflow_o=1; event_cnt_o=6; later acks deliver the 4 PCs in order.
- ESC_THRESHOLD=4, 4 detections with the req pending -> ack completes the current req, then halt_o=1 on the first HOLDOFF cycle; no further exc_req_o.
- LOCKED, assert clear_i -> halt_o=0, counters 0, FIFO empty, state IDLE; clear_i asserted during REQ -> no effect.
- Push on a full FIFO coinciding with ack -> push accepted; drop_cnt_o unchanged.
- With CFI_RESP_TIMEOUT_EN, TIMEOUT_CYCLES=16, never ack -> exc_req_o drops after 16 cycles and halt_o=1; ack on cycle 16 -> HOLDOFF, halt_o=0.
